// File: rtl/ll_tx_cred_mc.sv
// Multi-channel link-layer TX credit manager.
// Round-robin grant among channels that have data and credit.
module ll_tx_cred_mc #(
    parameter int NUM_CH          = 4,
    parameter int CRED_W          = 8,
    parameter int RET_W           = 4,
    parameter int CRED_COST       = 1,
    parameter int DEFAULT_TX_CRED = 1,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr,
    input  logic                     tx_online,
    input  logic [NUM_CH*CRED_W-1:0] init_credit,
    input  logic [NUM_CH*RET_W-1:0]  rx_credit,
    input  logic [NUM_CH-1:0]        txfifo_empty,
    input  logic                     tx_pop_ovrd,
    output logic [NUM_CH-1:0]        txfifo_pop,
    output logic                     tx_pushbit,
    output logic [CH_W-1:0]          tx_ch_sel,
    output logic [NUM_CH-1:0]        cred_ovf,
    output logic [NUM_CH*CRED_W-1:0] dbg_credit
);

    localparam int RC_W = $clog2(RET_W + 1);
    localparam int NX_W = CRED_W + 2;
    localparam logic [NX_W-1:0] CMAX = {2'b00, {CRED_W{1'b1}}};

    logic [CRED_W-1:0] cred     [NUM_CH];
    logic [CRED_W-1:0] cred_nxt [NUM_CH];
    logic [CRED_W-1:0] cred_ld  [NUM_CH];
    logic [NX_W-1:0]   cred_sum [NUM_CH];
    logic [RC_W-1:0]   ret_reg  [NUM_CH];
    logic [RC_W-1:0]   ret_cnt  [NUM_CH];

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] sat;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   ptr_nxt;
    logic              online_dly;
    logic              rise;
    logic              found;
    int                idx;

    assign rise       = tx_online & ~online_dly;
    assign req        = ~txfifo_empty & elig & {NUM_CH{tx_online}};
    assign tx_pushbit = |req;
    assign tx_ch_sel  = win;
    assign txfifo_pop = pop;
    assign cred_ovf   = ovf;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (tx_pushbit && !tx_pop_ovrd)
            pop[win] = 1'b1;
    end

    assign ptr_nxt = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ret_cnt[c] = '0;
            for (int b = 0; b < RET_W; b++)
                ret_cnt[c] = ret_cnt[c] + RC_W'(rx_credit[c*RET_W+b]);
            cred_sum[c] = NX_W'(cred[c]) + NX_W'(ret_reg[c])
                        - (pop[c] ? NX_W'(CRED_COST) : '0);
            sat[c]      = cred_sum[c] > CMAX;
            cred_nxt[c] = sat[c] ? '1 : cred_sum[c][CRED_W-1:0];
            cred_ld[c]  = (init_credit[c*CRED_W +: CRED_W] == '0)
                        ? CRED_W'(DEFAULT_TX_CRED)
                        : init_credit[c*CRED_W +: CRED_W];
            dbg_credit[c*CRED_W +: CRED_W] = cred[c];
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            online_dly <= 1'b0;
            ptr        <= '0;
            elig       <= '0;
            ovf        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cred[c]    <= '0;
                ret_reg[c] <= '0;
            end
        end else begin
            online_dly <= tx_online;
            for (int c = 0; c < NUM_CH; c++)
                ret_reg[c] <= ret_cnt[c];
            if (!tx_online) begin
                elig <= '0;
                ovf  <= '0;
                for (int c = 0; c < NUM_CH; c++)
                    cred[c] <= '0;
            end else if (rise) begin
                // Load wins over any pending return; nothing can pop here.
                for (int c = 0; c < NUM_CH; c++) begin
                    cred[c] <= cred_ld[c];
                    elig[c] <= cred_ld[c] >= CRED_W'(CRED_COST);
                end
            end else begin
                ovf <= ovf | sat;
                for (int c = 0; c < NUM_CH; c++) begin
                    cred[c] <= cred_nxt[c];
                    elig[c] <= cred_nxt[c] >= CRED_W'(CRED_COST);
                end
                if (|pop)
                    ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: doc/ll_tx_cred_mc.md
# ll_tx_cred_mc

Multi-channel transmit credit manager for the link layer. It keeps one credit counter per logical channel and arbitrates round-robin among channels that have both FIFO data and credit. It drives one pop per cycle to the winning channel's TX FIFO, plus the push bit and channel select, to the packetizer. It generalises the single-channel credit block with a parametrised channel count, counter width, credit return width, per-word credit cost, saturation and overflow reporting.

## Interface
- NUM_CH, 4, number of channels (1..16)
- CRED_W, 8, credit counter width per channel
- RET_W, 4, credit-return bits per channel per cycle; each set bit returns one credit
- CRED_COST, 1, credits consumed per popped word (1..2^CRED_W-1)
- DEFAULT_TX_CRED, 1, credit loaded when a channel's init credit is zero
- CH_W, max(1,$clog2(NUM_CH)), derived; channel select width
---
- clk_wr  in  1  clock
- rst_wr  in  1  reset, synchronous, active-high
- tx_online  in  1  link online; low forces the idle state
- init_credit  in  NUM_CH*CRED_W  per-channel initial credit, sampled on the online rising edge
- rx_credit  in  NUM_CH*RET_W  per-channel credit return bits
- txfifo_empty  in  NUM_CH  per-channel FIFO empty
- tx_pop_ovrd  in  1  packetizer holdoff; suppresses the pop only
- txfifo_pop  out  NUM_CH  one-hot-or-zero pop
- tx_pushbit  out  1  a word is presented this cycle
- tx_ch_sel  out  CH_W  channel of the presented word; valid when tx_pushbit=1
- cred_ovf  out  NUM_CH  sticky per-channel saturation flag
- dbg_credit  out  NUM_CH*CRED_W  current counters

## Operation
- **Reset.** rst_wr=1 clears all counters, eligibility, the pointer (to 0), cred_ovf, online_dly and the return registers. Every output is 0 during and after reset.
- **Online edge.** online_dly registers tx_online. A rising edge is tx_online & !online_dly. On that edge each counter loads init_credit[c], or DEFAULT_TX_CRED if that value is 0. rx credits registered for that cycle are discarded.
- **Offline.** While tx_online=0, counters, eligibility and cred_ovf are cleared each cycle and the pointer holds. tx_pushbit and txfifo_pop are forced to 0 combinationally.
- **Credit return.** ret_reg[c] is registered as popcount(rx_credit[c]), width $clog2(RET_W+1).
- **Next credit.** cred_nxt[c] = cred[c] - (pop[c] ? CRED_COST : 0) + ret_reg[c]. It is computed in CRED_W+2 bits.
  - If the result exceeds 2^CRED_W-1, it clamps to 2^CRED_W-1 and sets cred_ovf[c], which is sticky.
  - Underflow cannot occur by construction. The bench asserts this.
- **Eligibility.** elig_reg[c] is registered as (value written to cred[c]) >= CRED_COST. Because the value written already includes this cycle's decrement, a channel is never granted without CRED_COST credits.
- **Request.** req[c] = !txfifo_empty[c] & elig_reg[c] & tx_online.
- **Arbitration.** Round-robin starting at the pointer; the first requesting channel wins.
  - tx_pushbit = |req.
  - tx_ch_sel = winner.
  - txfifo_pop[winner] = tx_pushbit & !tx_pop_ovrd.
- **Pointer.** Advances to winner+1 (modulo NUM_CH) only when a pop occurs. Under override it holds, so the same channel is re-presented.
- **Debit rule.** A credit is debited only on pop, so override cycles cost no credit.
- **Simultaneous events.**
  - A pop and a return on the same channel in the same cycle are both applied.
  - An online rising edge takes precedence over pops and returns.
  - A reset asserted mid-traffic acts in the next edge.

## Timing
- tx_pushbit, tx_ch_sel and txfifo_pop are combinational from registered state, txfifo_empty, tx_pop_ovrd and tx_online. There are no combinational paths from rx_credit or init_credit.
- Online rising edge sampled at edge E: counters are loaded at E, and the first push is possible in the cycle after E.
- Credit return: rx_credit at cycle N is registered at the end of N and added to the counter at the end of N+1. dbg_credit shows it in N+2, and a pop using it is possible in N+2.
- Back-to-back pops on one channel are sustained while credit stays >= CRED_COST after each debit.

## Test plan
- **Online load.** NUM_CH=4, init {0,3,2,5}, raise tx_online with FIFOs empty → dbg_credit {1,3,2,5} one cycle later; no pop before the load.
- **Round robin.** All FIFOs non-empty, credits 10 each → pops ch0,1,2,3,0,1 on consecutive cycles; each counter decreases by 1 per grant.
- **Credit exhaustion.** Only ch1 has data, init 2, no returns → exactly 2 pops, then tx_pushbit=0. Drive rx_credit[1]=4'b0011 at cycle N → pops resume at N+2, exactly 2 of them.
- **Override.** ch2 data, tx_pop_ovrd=1 for 3 cycles → tx_pushbit=1, tx_ch_sel=2, txfifo_pop=0, credit unchanged. On release, ch2 pops first.
- **Saturation.** CRED_W=8, ch0 at 254, rx_credit[0]=4'b1111 → counter 255 and cred_ovf[0]=1, held until tx_online drops.
- **Offline mid-traffic.** Drop tx_online during streaming → pushbit and pop are 0 the same cycle and counters are 0 next cycle. Re-raise → init values are reloaded and arbitration resumes from the held pointer.
